// File: rtl/feature_pkg.sv
// -----------------------------------------------------------------------------
// feature_pkg
//   Shared definitions for the feature element-wise datapath:
//     - mode_e          : operation encodings carried on mode_in
//     - sat_bound_t     : wide signed type used to build saturation bounds
//     - sat_hi / sat_lo : largest / smallest value representable in a signed
//                         field of the given width, used as clamp limits
// -----------------------------------------------------------------------------
package feature_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,  // x1 - x2
    MODE_MAX  = 2'd2,  // signed max(x1, x2)
    MODE_RSVD = 2'd3   // reserved, executes as ADD
  } mode_e;

  // Wide enough for any practical lane width; callers slice what they need.
  localparam int SAT_CALC_WIDTH = 65;
  typedef logic signed [SAT_CALC_WIDTH-1:0] sat_bound_t;

  // 2^(width-1) - 1
  function automatic sat_bound_t sat_hi(input int width);
    sat_bound_t one;
    one = sat_bound_t'(1);
    return (one <<< (width - 1)) - one;
  endfunction

  // -2^(width-1)
  function automatic sat_bound_t sat_lo(input int width);
    sat_bound_t one;
    one = sat_bound_t'(1);
    return -(one <<< (width - 1));
  endfunction

endpackage

// File: rtl/feature_eltwise_lane.sv
// -----------------------------------------------------------------------------
// feature_eltwise_lane
//   One lane of the element-wise pipeline. Stage 1 registers the operation
//   result one bit wider than the operands so ADD/SUB never wrap; stage 2
//   registers the result clamped back into FEATURE_WIDTH bits.
//
//   Build option: define FEATURE_ELTWISE_RELU_EN to clamp negative saturated
//   results to zero in stage 2 (latency unchanged).
//
//   Ports
//     system_clk, rst_n : clock, asynchronous active-low reset
//     s1_en             : load stage 1 with the current operands (beat accepted)
//     s2_en             : load stage 2 from stage 1
//     mode_in           : mode_e encoding, used when s1_en is high
//     x1_in, x2_in      : signed operands
//     y_out             : stage 2 result
// -----------------------------------------------------------------------------
module feature_eltwise_lane
  import feature_pkg::*;
#(
  parameter int FEATURE_WIDTH = 16
) (
  input  logic                     system_clk,
  input  logic                     rst_n,
  input  logic                     s1_en,
  input  logic                     s2_en,
  input  logic [1:0]               mode_in,
  input  logic [FEATURE_WIDTH-1:0] x1_in,
  input  logic [FEATURE_WIDTH-1:0] x2_in,
  output logic [FEATURE_WIDTH-1:0] y_out
);

  localparam sat_bound_t SAT_HI_FULL = sat_hi(FEATURE_WIDTH);
  localparam sat_bound_t SAT_LO_FULL = sat_lo(FEATURE_WIDTH);
  localparam logic signed [FEATURE_WIDTH:0] SAT_HI = SAT_HI_FULL[FEATURE_WIDTH:0];
  localparam logic signed [FEATURE_WIDTH:0] SAT_LO = SAT_LO_FULL[FEATURE_WIDTH:0];

  logic signed [FEATURE_WIDTH:0]   x1_w;
  logic signed [FEATURE_WIDTH:0]   x2_w;
  logic signed [FEATURE_WIDTH:0]   wide_calc;
  logic signed [FEATURE_WIDTH:0]   wide_d;
  logic signed [FEATURE_WIDTH:0]   wide_q;
  logic signed [FEATURE_WIDTH-1:0] y_sat;
  logic        [FEATURE_WIDTH-1:0] y_d;
  logic        [FEATURE_WIDTH-1:0] y_q;

  // Stage 1: compute at FEATURE_WIDTH+1 bits.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here via the defaults below) so no latch is inferred.
    wide_calc = '0;
    x1_w      = {x1_in[FEATURE_WIDTH-1], x1_in};
    x2_w      = {x2_in[FEATURE_WIDTH-1], x2_in};
    case (mode_e'(mode_in))
      MODE_SUB: wide_calc = x1_w - x2_w;
      MODE_MAX: wide_calc = (x1_w > x2_w) ? x1_w : x2_w;
      default:  wide_calc = x1_w + x2_w;  // ADD and reserved
    endcase
    wide_d = s1_en ? wide_calc : wide_q;
  end

  // Stage 2: clamp into the representable range, optional ReLU.
  always_comb begin
    if (wide_q > SAT_HI) begin
      y_sat = SAT_HI[FEATURE_WIDTH-1:0];
    end else if (wide_q < SAT_LO) begin
      y_sat = SAT_LO[FEATURE_WIDTH-1:0];
    end else begin
      y_sat = wide_q[FEATURE_WIDTH-1:0];
    end
`ifdef FEATURE_ELTWISE_RELU_EN
    if (y_sat[FEATURE_WIDTH-1]) begin
      y_sat = '0;
    end
`endif
    y_d = s2_en ? y_sat : y_q;
  end

  // NOTE: datapath registers are reset here because the result bus must read
  // zero after reset; pure pipeline data that nobody observes could skip it.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wide_q <= '0;
      y_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wide_q <= wide_d;
      y_q    <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: rtl/feature_eltwise.sv
// -----------------------------------------------------------------------------
// feature_eltwise
//   Two-stage element-wise ADD / SUB / MAX over LANES signed lanes with
//   saturation, valid/ready handshaking on both sides and a per-tile beat
//   counter that marks the final beat of each tile with feature_last_out.
//
//   Build option: FEATURE_ELTWISE_RELU_EN (see feature_eltwise_lane).
//
//   Ports
//     system_clk, rst_n        : clock, asynchronous active-low reset
//     mode_in                  : 0 ADD, 1 SUB, 2 MAX, 3 ADD; per accepted beat
//     beat_total_in            : beats per tile, sampled on a tile's first beat
//                                (0 behaves as 1)
//     feature_x1_in/x2_in      : operands, lane i at [FEATURE_WIDTH*i +: FEATURE_WIDTH]
//     feature_x_valid_in/ready_out : input handshake
//     feature_data_out         : saturated results, same packing
//     feature_data_valid_out/ready_in : output handshake
//     feature_last_out         : result is the final beat of its tile
// -----------------------------------------------------------------------------
module feature_eltwise
  import feature_pkg::*;
#(
  parameter int FEATURE_WIDTH = 16,
  parameter int LANES         = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             system_clk,
  input  logic                             rst_n,
  input  logic [1:0]                       mode_in,
  input  logic [CNT_WIDTH-1:0]             beat_total_in,
  input  logic [FEATURE_WIDTH*LANES-1:0]   feature_x1_in,
  input  logic [FEATURE_WIDTH*LANES-1:0]   feature_x2_in,
  input  logic                             feature_x_valid_in,
  output logic                             feature_x_ready_out,
  output logic [FEATURE_WIDTH*LANES-1:0]   feature_data_out,
  output logic                             feature_data_valid_out,
  input  logic                             feature_data_ready_in,
  output logic                             feature_last_out
);

  logic                 s1_valid_d, s1_valid_q;
  logic                 s1_last_d,  s1_last_q;
  logic                 s2_valid_d, s2_valid_q;
  logic                 s2_last_d,  s2_last_q;
  logic [CNT_WIDTH-1:0] beat_cnt_d, beat_cnt_q;
  logic [CNT_WIDTH-1:0] beat_total_d, beat_total_q;

  logic                 s1_adv;
  logic                 s2_adv;
  logic                 accept;
  logic                 s2_load;
  logic [CNT_WIDTH-1:0] tile_total;
  logic                 beat_is_last;

  // Handshake: a stage may take new data when it is empty or is itself
  // emptying this cycle, so ready ripples back combinationally from
  // feature_data_ready_in and a full pipe still streams one beat per cycle.
  always_comb begin
    s2_adv              = !s2_valid_q || feature_data_ready_in;
    s1_adv              = !s1_valid_q || s2_adv;
    feature_x_ready_out = !s1_valid_q || s1_adv;
    accept              = feature_x_valid_in && feature_x_ready_out;
    s2_load             = s2_adv && s1_valid_q;
  end

  // Tile counter. On the first beat of a tile the live beat_total_in is used;
  // later beats use the copy latched on that first beat.
  always_comb begin
    tile_total = (beat_cnt_q == '0) ? beat_total_in : beat_total_q;
    if (tile_total == '0) begin
      tile_total = CNT_WIDTH'(1);
    end
    beat_is_last = (beat_cnt_q == tile_total - CNT_WIDTH'(1));

    beat_cnt_d   = beat_cnt_q;
    beat_total_d = beat_total_q;
    if (accept) begin
      beat_total_d = tile_total;
      beat_cnt_d   = beat_is_last ? '0 : beat_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Stage valid/last tracking; last follows its data through both stages.
  always_comb begin
    s1_valid_d = s1_adv ? accept : s1_valid_q;
    s1_last_d  = accept ? beat_is_last : s1_last_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_last_d  = s2_load ? s1_last_q : s2_last_q;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      beat_cnt_q   <= '0;
      beat_total_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s2_valid_q   <= s2_valid_d;
      s2_last_q    <= s2_last_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_total_q <= beat_total_d;
    end
  end

  assign feature_data_valid_out = s2_valid_q;
  assign feature_last_out       = s2_last_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    feature_eltwise_lane #(
      .FEATURE_WIDTH (FEATURE_WIDTH)
    ) u_lane (
      .system_clk (system_clk),
      .rst_n      (rst_n),
      .s1_en      (accept),
      .s2_en      (s2_load),
      .mode_in    (mode_in),
      .x1_in      (feature_x1_in[FEATURE_WIDTH*i +: FEATURE_WIDTH]),
      .x2_in      (feature_x2_in[FEATURE_WIDTH*i +: FEATURE_WIDTH]),
      .y_out      (feature_data_out[FEATURE_WIDTH*i +: FEATURE_WIDTH])
    );
  end

endmodule

// File: tb/tb_feature_eltwise.sv
// -----------------------------------------------------------------------------
// tb_feature_eltwise
//   Scoreboard bench for feature_eltwise (default parameters). Accepted beats
//   push their expected result/last onto a queue; transferred results pop and
//   compare. Scenario tasks add direct checks on latency, constants, stall
//   behaviour, tile marking and reset.
// -----------------------------------------------------------------------------
module tb_feature_eltwise;

  localparam int W  = 16;
  localparam int L  = 8;
  localparam int CW = 16;
  localparam int DW = W * L;
  localparam int SAT_MAX = (1 << (W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (W - 1));

  logic          system_clk;
  logic          rst_n;
  logic [1:0]    mode_in;
  logic [CW-1:0] beat_total_in;
  logic [DW-1:0] feature_x1_in;
  logic [DW-1:0] feature_x2_in;
  logic          feature_x_valid_in;
  logic          feature_x_ready_out;
  logic [DW-1:0] feature_data_out;
  logic          feature_data_valid_out;
  logic          feature_data_ready_in;
  logic          feature_last_out;

  feature_eltwise #(
    .FEATURE_WIDTH (W),
    .LANES         (L),
    .CNT_WIDTH     (CW)
  ) dut (
    .system_clk             (system_clk),
    .rst_n                  (rst_n),
    .mode_in                (mode_in),
    .beat_total_in          (beat_total_in),
    .feature_x1_in          (feature_x1_in),
    .feature_x2_in          (feature_x2_in),
    .feature_x_valid_in     (feature_x_valid_in),
    .feature_x_ready_out    (feature_x_ready_out),
    .feature_data_out       (feature_data_out),
    .feature_data_valid_out (feature_data_valid_out),
    .feature_data_ready_in  (feature_data_ready_in),
    .feature_last_out       (feature_last_out)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            n_vec;
  int            n_err;
  int            n_xfer;
  logic [31:0]   hist;       // last flags of transfers, newest in bit 0
  logic [DW-1:0] last_data;  // most recent transferred result
  int            m_cnt;
  int            m_total;
  logic          held_valid;
  logic [DW-1:0] held_data;
  logic          held_last;

  // ---------------------------------------------------------------- helpers
  function automatic logic [DW-1:0] splat(input int v);
    logic [DW-1:0] r;
    logic [31:0]   u;
    u = v;
    for (int i = 0; i < L; i++) r[i*W +: W] = u[W-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp(input int base, input int step);
    logic [DW-1:0] r;
    logic [31:0]   u;
    for (int i = 0; i < L; i++) begin
      u = base + i * step;
      r[i*W +: W] = u[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    logic [31:0]   u;
    for (int i = 0; i < L; i++) begin
      u = $urandom;
      r[i*W +: W] = u[W-1:0];
    end
    return r;
  endfunction

  // Reference lane arithmetic in plain integers.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [1:0]    m);
    logic [DW-1:0]       res;
    logic signed [W-1:0] la, lb;
    int                  sa, sbv, r;
    logic [31:0]         u;
    res = '0;
    for (int i = 0; i < L; i++) begin
      la  = a[i*W +: W];
      lb  = b[i*W +: W];
      sa  = int'(la);
      sbv = int'(lb);
      case (m)
        2'd1:    r = sa - sbv;
        2'd2:    r = (sa > sbv) ? sa : sbv;
        default: r = sa + sbv;
      endcase
      if (r > SAT_MAX) r = SAT_MAX;
      if (r < SAT_MIN) r = SAT_MIN;
`ifdef FEATURE_ELTWISE_RELU_EN
      if (r < 0) r = 0;
`endif
      u = r;
      res[i*W +: W] = u[W-1:0];
    end
    return res;
  endfunction

  // Runs forever at every falling edge: stall stability, result pop/compare,
  // then push of the beat that will be accepted at the coming rising edge.
  task automatic scoreboard_loop();
    exp_t e;
    int   tot;
    forever begin
      @(negedge system_clk);
      if (!rst_n) begin
        sb.delete();
        m_cnt      = 0;
        m_total    = 0;
        held_valid = 1'b0;
      end else begin
        if (held_valid) begin
          n_vec++;
          if (feature_data_valid_out !== 1'b1 || feature_data_out !== held_data ||
              feature_last_out !== held_last) begin
            n_err++;
            $display("FAIL stall_hold: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                     feature_data_valid_out, feature_data_out, feature_last_out, held_data, held_last);
          end
        end
        held_valid = feature_data_valid_out && !feature_data_ready_in;
        held_data  = feature_data_out;
        held_last  = feature_last_out;

        if (feature_data_valid_out && feature_data_ready_in) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: data=%h last=%0b, required no result",
                     feature_data_out, feature_last_out);
          end else begin
            e = sb.pop_front();
            if (feature_data_out !== e.data || feature_last_out !== e.last) begin
              n_err++;
              $display("FAIL result: data=%h last=%0b, required data=%h last=%0b",
                       feature_data_out, feature_last_out, e.data, e.last);
            end
          end
          last_data = feature_data_out;
          hist      = {hist[30:0], feature_last_out};
          n_xfer++;
        end

        if (feature_x_valid_in && feature_x_ready_out) begin
          tot = (m_cnt == 0) ? int'(beat_total_in) : m_total;
          if (tot == 0) tot = 1;
          if (m_cnt == 0) m_total = tot;
          e.last = (m_cnt == tot - 1);
          m_cnt  = e.last ? 0 : m_cnt + 1;
          e.data = model(feature_x1_in, feature_x2_in, mode_in);
          sb.push_back(e);
        end
      end
    end
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] m, input logic [CW-1:0] tot);
    feature_x1_in      = a;
    feature_x2_in      = b;
    mode_in            = m;
    beat_total_in      = tot;
    feature_x_valid_in = 1'b1;
    @(negedge system_clk);
    for (int w = 0; w < 64 && !feature_x_ready_out; w++) @(negedge system_clk);
    if (!feature_x_ready_out) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: ready_out=%0b, required 1 within 64 cycles", feature_x_ready_out);
    end
    @(posedge system_clk);
    #1;
    feature_x_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 200 && (sb.size() != 0 || feature_data_valid_out); w++)
      @(negedge system_clk);
    n_vec++;
    if (sb.size() != 0 || feature_data_valid_out) begin
      n_err++;
      $display("FAIL drain_timeout: pending=%0d valid_out=%0b, required 0 and 0",
               sb.size(), feature_data_valid_out);
    end
    @(posedge system_clk);
    #1;
  endtask

  // -------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst_n                 = 1'b0;
    feature_x_valid_in    = 1'b0;
    feature_data_ready_in = 1'b1;
    mode_in               = 2'd0;
    beat_total_in         = '0;
    feature_x1_in         = '0;
    feature_x2_in         = '0;
    repeat (2) @(negedge system_clk);
    n_vec++;
    if (feature_data_valid_out !== 1'b0 || feature_last_out !== 1'b0 || feature_data_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%0b last=%0b data=%h, required 0 0 0",
               feature_data_valid_out, feature_last_out, feature_data_out);
    end
    @(posedge system_clk);
    #1;
    rst_n = 1'b1;
    @(negedge system_clk);
    n_vec++;
    if (feature_x_ready_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: ready_out=%0b, required 1", feature_x_ready_out);
    end
    @(posedge system_clk);
    #1;
  endtask

  task automatic test_add_latency();
    send(splat(100), splat(27), 2'd0, CW'(1));
    @(negedge system_clk);
    n_vec++;
    if (feature_data_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: valid_out=%0b one cycle after accept, required 0",
               feature_data_valid_out);
    end
    @(negedge system_clk);
    n_vec++;
    if (feature_data_valid_out !== 1'b1 || feature_data_out !== splat(127)) begin
      n_err++;
      $display("FAIL add_latency: valid_out=%0b data=%h two cycles after accept, required 1 %h",
               feature_data_valid_out, feature_data_out, splat(127));
    end
    drain();
  endtask

  task automatic test_saturation();
    logic [DW-1:0] exp_neg;
`ifdef FEATURE_ELTWISE_RELU_EN
    exp_neg = splat(0);
`else
    exp_neg = splat(-32768);
`endif
    send(splat(32000), splat(1000), 2'd0, CW'(1));
    drain();
    n_vec++;
    if (last_data !== splat(32767)) begin
      n_err++;
      $display("FAIL sat_add: data=%h, required %h", last_data, splat(32767));
    end
    send(splat(-32000), splat(1000), 2'd1, CW'(1));
    drain();
    n_vec++;
    if (last_data !== exp_neg) begin
      n_err++;
      $display("FAIL sat_sub: data=%h, required %h", last_data, exp_neg);
    end
  endtask

  task automatic test_max_mode3();
    send(splat(-5), splat(3), 2'd2, CW'(1));
    drain();
    n_vec++;
    if (last_data !== splat(3)) begin
      n_err++;
      $display("FAIL max: data=%h, required %h", last_data, splat(3));
    end
    send(splat(4), splat(4), 2'd3, CW'(1));
    drain();
    n_vec++;
    if (last_data !== splat(8)) begin
      n_err++;
      $display("FAIL mode3_add: data=%h, required %h", last_data, splat(8));
    end
  endtask

  task automatic test_back_to_back_stall();
    int base;
    base = n_xfer;
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(ramp(k * 100 - 300, 7), ramp(50 - k, -3), 2'(k % 3), CW'(1));
      end
      begin
        for (int c = 0; c < 8; c++) begin
          feature_data_ready_in = !(c >= 3 && c <= 6);
          @(negedge system_clk);
          if (c == 6) begin
            n_vec++;
            if (feature_x_ready_out !== 1'b0) begin
              n_err++;
              $display("FAIL stall_ready: ready_out=%0b with both stages full, required 0",
                       feature_x_ready_out);
            end
          end
          @(posedge system_clk);
          #1;
        end
        feature_data_ready_in = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (n_xfer - base != 10) begin
      n_err++;
      $display("FAIL stall_count: results=%0d, required 10", n_xfer - base);
    end
  endtask

  task automatic test_tiles();
    int base;
    base = n_xfer;
    for (int k = 0; k < 4; k++) send(ramp(k, 1), ramp(1, 2), 2'd0, CW'(4));
    for (int k = 0; k < 3; k++) send(ramp(k, 3), ramp(2, 1), 2'd1, CW'(0));
    drain();
    n_vec++;
    if (n_xfer - base != 7 || hist[6:0] !== 7'b0001111) begin
      n_err++;
      $display("FAIL tile_last: results=%0d lasts=%b, required 7 0001111", n_xfer - base, hist[6:0]);
    end
  endtask

  task automatic test_reset_mid_tile();
    int base;
    send(splat(1), splat(2), 2'd0, CW'(4));
    send(splat(3), splat(4), 2'd0, CW'(4));
    rst_n = 1'b0;
    @(negedge system_clk);
    n_vec++;
    if (feature_data_valid_out !== 1'b0 || feature_data_out !== '0) begin
      n_err++;
      $display("FAIL midtile_reset: valid=%0b data=%h, required 0 0",
               feature_data_valid_out, feature_data_out);
    end
    @(posedge system_clk);
    #1;
    rst_n = 1'b1;
    base  = n_xfer;
    for (int k = 0; k < 3; k++) send(splat(10 + k), splat(1), 2'd0, CW'(3));
    drain();
    n_vec++;
    if (n_xfer - base != 3 || hist[2:0] !== 3'b001) begin
      n_err++;
      $display("FAIL midtile_restart: results=%0d lasts=%b, required 3 001", n_xfer - base, hist[2:0]);
    end
  endtask

  task automatic test_random();
    int   base;
    logic done;
    base = n_xfer;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send(rand_vec(), rand_vec(), 2'($urandom_range(0, 3)), CW'($urandom_range(0, 3)));
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 1000 && !done; c++) begin
          feature_data_ready_in = ($urandom_range(0, 3) != 0);
          @(posedge system_clk);
          #1;
        end
        feature_data_ready_in = 1'b1;
      end
    join
    // Finish any tile left open so later beats start clean.
    while (m_cnt != 0) send(rand_vec(), rand_vec(), 2'd0, CW'(1));
    drain();
    n_vec++;
    if (n_xfer - base < 40) begin
      n_err++;
      $display("FAIL random_count: results=%0d, required at least 40", n_xfer - base);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    n_xfer     = 0;
    hist       = '0;
    last_data  = '0;
    m_cnt      = 0;
    m_total    = 0;
    held_valid = 1'b0;
    held_data  = '0;
    held_last  = 1'b0;
    fork
      scoreboard_loop();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_add_latency();
    test_saturation();
    test_max_mode3();
    test_back_to_back_stall();
    test_tiles();
    test_reset_mid_tile();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/feature_eltwise.md
FEATURE_ELTWISE -- requirements
Module: feature_eltwise

Interface
REQ-001 Parameter FEATURE_WIDTH, default 16: bits per lane, signed two's complement.
REQ-002 Parameter LANES, default 8: lanes per beat, range 1..32.
REQ-003 Parameter CNT_WIDTH, default 16: width of the tile beat counter.
REQ-004 Reset rst_n, asynchronous, active-low; clock system_clk.
REQ-005 system_clk  in  1  clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 mode_in  in  2  operation: 0 ADD, 1 SUB (x1-x2), 2 MAX, 3 reserved (acts as ADD); sampled per accepted beat.
REQ-008 beat_total_in  in  CNT_WIDTH  beats per tile; sampled on the first beat of each tile.
REQ-009 feature_x1_in  in  FEATURE_WIDTH*LANES  operand 1, lane i at bits [FEATURE_WIDTH*i +: FEATURE_WIDTH].
REQ-010 feature_x2_in  in  FEATURE_WIDTH*LANES  operand 2, same packing.
REQ-011 feature_x_valid_in  in  1  operands valid.
REQ-012 feature_x_ready_out  out  1  block accepts a beat this cycle.
REQ-013 feature_data_out  out  FEATURE_WIDTH*LANES  result, same packing.
REQ-014 feature_data_valid_out  out  1  result valid.
REQ-015 feature_data_ready_in  in  1  downstream accepts the result.
REQ-016 feature_last_out  out  1  result is the final beat of the tile.

Function
REQ-017 A beat SHALL be accepted when feature_x_valid_in and feature_x_ready_out are both high; a result SHALL transfer when feature_data_valid_out and feature_data_ready_in are both high.
REQ-018 The block SHALL be a 2-stage pipeline (S1: widened compute, S2: saturate/post-process); latency SHALL be 2 cycles from acceptance to valid_out with no stall.
REQ-019 S2 SHALL advance when S2 is empty or its result transfers; S1 SHALL advance when S1 is empty or S2 advances; feature_x_ready_out = !S1_valid || S1_advance (combinational path from feature_data_ready_in is permitted).
REQ-020 With no stall, sustained throughput SHALL be one beat per cycle.
REQ-021 While valid_out is high and ready_in low, feature_data_out and feature_last_out SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-022 S1 SHALL compute each lane at FEATURE_WIDTH+1 bits: ADD x1+x2, SUB x1-x2, MAX signed max(x1,x2).
REQ-023 S2 SHALL saturate each lane to [-2^(FEATURE_WIDTH-1), 2^(FEATURE_WIDTH-1)-1]; no wrap-around.
REQ-024 A beat counter SHALL increment per accepted beat; the beat with index beat_total-1 SHALL carry last=1, after which the counter returns to 0 and the next beat starts a new tile.
REQ-025 beat_total_in = 0 SHALL be treated as 1 (every beat last).
REQ-026 The last flag SHALL travel with its data through both stages.

Reset
REQ-027 On rst_n low, S1/S2 valid, beat counter, latched beat_total, feature_data_valid_out, feature_last_out and feature_data_out SHALL clear to 0 asynchronously; feature_x_ready_out SHALL read 1 after reset.
REQ-028 Reset mid-tile SHALL discard in-flight beats; the next accepted beat SHALL start a new tile.

Configuration
REQ-029 With macro FEATURE_ELTWISE_RELU_EN defined, S2 SHALL clamp negative saturated results to 0; without it, saturated results SHALL pass unchanged; latency SHALL be 2 in both builds.

Structure
REQ-030 Mode encodings and the saturation bound constants SHALL live in the shared package feature_pkg.
REQ-031 Per-lane compute/saturate/ReLU SHALL be a sub-module feature_eltwise_lane, instantiated LANES times; handshake and counter logic stay in the top.

Verification
REQ-032 ADD, all lanes 100+27, ready_in=1 -> 127 per lane, valid_out exactly 2 cycles after accept.
REQ-033 Saturation, FEATURE_WIDTH=16: ADD 32000+1000 -> 32767; SUB -32000-1000 -> -32768 (0 with FEATURE_ELTWISE_RELU_EN).
REQ-034 MAX of -5 and 3 -> 3; mode 3 on 4,4 -> 8.
REQ-035 Backpressure: 10 back-to-back beats, ready_in low for cycles 3-6 -> all 10 results in order, data stable while stalled, ready_out low once both stages are full.
REQ-036 Tiles: beat_total_in=4 then 0 -> last on beats 4, then on every beat; rst_n pulsed after beat 2 of a tile -> valid_out drops, next beat counts as beat 1.
